vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Produces the (x,y) raster scan, hsync/vsync and visible-region flag that every pixel-region
//  block (player bar, notes, score) decodes against. It is the driving end of the x/y pixel
//  interface. It runs from the system clock using a clock-enable divider, not a derived clock.
//  Default timing is 640x480@60 Hz from a 100 MHz clk.
// PARAMETERS
//  CLK_DIV    4    system clocks per pixel (>=1; 1 = tick every cycle)
//  H_DISPLAY  640  visible pixels per line
//  H_FRONT    16   horizontal front porch, in pixels
//  H_SYNC     96   hsync pulse width, in pixels
//  H_BACK     48   horizontal back porch, in pixels
//  V_DISPLAY  480  visible lines per frame
//  V_FRONT    10   vertical front porch, in lines
//  V_SYNC     2    vsync pulse width, in lines
//  V_BACK     33   vertical back porch, in lines
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-high
//  x            out  10  current horizontal position, 0..H_TOTAL-1
//  y            out  10  current vertical position, 0..V_TOTAL-1
//  hsync        out  1   horizontal sync, active-low
//  vsync        out  1   vertical sync, active-low
//  video_on     out  1   high when x<H_DISPLAY and y<V_DISPLAY
//  pixel_tick   out  1   one-clk pulse; high in the cycle x/y take a new value
//  line_start   out  1   high with pixel_tick when x==0
//  frame_start  out  1   high with pixel_tick when x==0 and y==0
// BEHAVIOUR
//  - Derived constants: H_TOTAL = sum of the four H_* parameters (800), V_TOTAL = sum of the
//    four V_* parameters (525). Elaboration fails if H_TOTAL>1024, V_TOTAL>1024 or CLK_DIV<1.
//  - Divider: div_cnt counts 0..CLK_DIV-1 and wraps. An internal tick fires when div_cnt==CLK_DIV-1.
//  - Internal counters h_cnt and v_cnt are 10 bits. On each internal tick:
//      the output registers load the decode of (h_cnt, v_cnt);
//      then h_cnt increments, wrapping H_TOTAL-1 -> 0.
//      On that wrap, v_cnt increments, wrapping V_TOTAL-1 -> 0.
//  - All outputs are registered. Latency is 1 clk from the internal tick to the outputs.
//    Between ticks, x, y, hsync, vsync and video_on hold their values.
//    pixel_tick, line_start and frame_start are 0 between ticks.
//  - hsync=0 iff H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
//  - vsync=0 iff V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC (490..491).
//  - Reset values: div_cnt=0, h_cnt=0, v_cnt=0; x=0, y=0, hsync=1, vsync=1, video_on=0,
//    pixel_tick=0, line_start=0, frame_start=0.
//  - First tick after reset: x=0, y=0, video_on=1, pixel_tick=1, line_start=1, frame_start=1.
//  - Reset asserted mid-frame clears everything immediately (asynchronous). After release the
//    scan restarts at (0,0); no partial line is completed.
//  - At the line and frame corners (h and v wrap together at 799,524) the next output is
//    (0,0) with frame_start=1. Counters never reach H_TOTAL or V_TOTAL.
//  - CLK_DIV=1: the divider is bypassed, the tick is constant 1, and outputs change every clk.
// STRUCTURE
//  - Timing constants (H_*, V_*, H_TOTAL, V_TOTAL) live in the shared display constants include,
//    alongside PLAYER_Y, COLUMNn_X and NOTE_* so that consumers and this block agree.
//  - One sub-module: pixel_tick_gen (parameter CLK_DIV; ports clk, rst, tick), the
//    clock-enable divider.
//  - Counter/decode logic and output registers stay in this module.
// TESTING
//  1. rst=1 for 3 clks, then release -> all outputs at reset values until the 4th clk (CLK_DIV=4).
//     Then x=0, y=0, frame_start=1, video_on=1.
//  2. Run 1 line -> pixel_tick every 4 clks; 800 ticks per line.
//     hsync low for exactly 96 ticks starting at x=656; video_on falls at x=640.
//  3. Run 1 frame -> frame_start period exactly 1,680,000 clks.
//     vsync low for y=490..491 only (1600 ticks); video_on=0 for all y>=480.
//  4. Wrap check -> after (799,524) the next tick gives (0,0) with line_start=1 and frame_start=1.
//     x never equals 800 and y never equals 525.
//  5. Assert rst at (300,200) mid-divider -> outputs reset the same cycle.
//     After release, the scan restarts from (0,0) with a full 4-clk divider period.
//  6. CLK_DIV=1 build -> pixel_tick constant 1 after reset, x increments every clk,
//     and a frame is 420,000 clks.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared display constants: raster timing plus the geometry that pixel-region blocks decode against.
package vga_timing_gen_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned VGA_CLK_DIV   = 4;
  localparam int unsigned VGA_H_DISPLAY = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_DISPLAY = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int unsigned PLAYER_Y  = 440;
  localparam int unsigned COLUMN0_X = 160;
  localparam int unsigned COLUMN1_X = 240;
  localparam int unsigned COLUMN2_X = 320;
  localparam int unsigned COLUMN3_X = 400;
  localparam int unsigned NOTE_W    = 64;
  localparam int unsigned NOTE_H    = 16;

  // Half-open span test done at 32 bits so an end bound of 1024 cannot alias to 0.
  function automatic logic in_span(coord_t v, int unsigned lo, int unsigned hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// x/y pixel interface: the timing generator drives it, pixel-region blocks consume it.
interface vga_timing_gen_if;
  import vga_timing_gen_pkg::*;

  coord_t x;
  coord_t y;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   pixel_tick;
  logic   line_start;
  logic   frame_start;

  modport master (
    output x, y, hsync, vsync, video_on, pixel_tick, line_start, frame_start
  );

  modport slave (
    input x, y, hsync, vsync, video_on, pixel_tick, line_start, frame_start
  );

endinterface

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// Clock-enable divider: tick is high one clk in every CLK_DIV, or constantly when CLK_DIV is 1.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  if (CLK_DIV <= 1) begin : g_bypass
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst};
    assign tick      = 1'b1;
  end else begin : g_div
    localparam int unsigned W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        div_cnt <= '0;
      end else if (div_cnt == LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end

    assign tick = (div_cnt == LAST);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: x/y position, active-low syncs and visible flag, one registered update per pixel tick.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
  parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK
) (
  input  logic               clk,
  input  logic               rst,
  vga_timing_gen_if.master   vga
);

  localparam int unsigned H_TOTAL    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START   = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_END     = HS_START + H_SYNC;
  localparam int unsigned VS_START   = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_END     = VS_START + V_SYNC;
  localparam coord_t      H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t      V_LAST     = coord_t'(V_TOTAL - 1);

  if (CLK_DIV < 1 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
    $error("vga_timing_gen: CLK_DIV must be >=1 and H/V totals must not exceed 1024");
  end

  logic   tick;
  coord_t h_cnt;
  coord_t v_cnt;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Outputs present the position the counters held at the tick, so they trail h_cnt/v_cnt by one pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      vga.x           <= '0;
      vga.y           <= '0;
      vga.hsync       <= 1'b1;
      vga.vsync       <= 1'b1;
      vga.video_on    <= 1'b0;
      vga.pixel_tick  <= 1'b0;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      vga.pixel_tick  <= tick;
      vga.line_start  <= tick && (h_cnt == '0);
      vga.frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
      if (tick) begin
        vga.x        <= h_cnt;
        vga.y        <= v_cnt;
        vga.hsync    <= !in_span(h_cnt, HS_START, HS_END);
        vga.vsync    <= !in_span(v_cnt, VS_START, VS_END);
        vga.video_on <= in_span(h_cnt, 0, H_DISPLAY) && in_span(v_cnt, 0, V_DISPLAY);
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          if (v_cnt == V_LAST) begin
            v_cnt <= '0;
          end else begin
            v_cnt <= v_cnt + 1'b1;
          end
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunk raster (15x10) with a scoreboard fed by an independent timing model.
module tb_vga_timing_gen;
  import vga_timing_gen_pkg::*;

  localparam int unsigned DIV = 4;
  localparam int unsigned HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int unsigned VD = 6, VF = 1, VS = 2, VB = 1;
  localparam int unsigned HT = HD + HF + HS + HB;
  localparam int unsigned VT = VD + VF + VS + VB;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       line_start;
    logic       frame_start;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if vga ();
  vga_timing_gen_if vga1 ();

  vga_timing_gen #(
    .CLK_DIV(DIV), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .vga(vga)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut1 (
    .clk(clk), .rst(rst), .vga(vga1)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference timing model: runs its own divider and counters, pushes the expected output per tick.
  exp_t        sb[$];
  int unsigned mdiv, mh, mv;

  always @(posedge clk) begin
    if (rst) begin
      mdiv = 0; mh = 0; mv = 0;
      sb.delete();
    end else if (mdiv == DIV - 1) begin
      sb.push_back('{x: 10'(mh), y: 10'(mv),
                     hsync: !(mh >= HD + HF && mh < HD + HF + HS),
                     vsync: !(mv >= VD + VF && mv < VD + VF + VS),
                     video_on: (mh < HD) && (mv < VD),
                     line_start: (mh == 0),
                     frame_start: (mh == 0) && (mv == 0)});
      mdiv = 0;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end else begin
      mdiv = mdiv + 1;
    end
  end

  exp_t        got, want;
  logic [22:0] prev_hold, cur_hold;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0};
    end else begin
      got      = '{vga.x, vga.y, vga.hsync, vga.vsync, vga.video_on, vga.line_start, vga.frame_start};
      cur_hold = {vga.x, vga.y, vga.hsync, vga.vsync, vga.video_on};
      if (vga.pixel_tick) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 0, 1);
        end else begin
          want = sb.pop_front();
          check("sb_pixel", 32'(got), 32'(want));
        end
      end else begin
        check("idle_pulses", {vga.line_start, vga.frame_start}, 0);
        check("hold_outputs", 32'(cur_hold), 32'(prev_hold));
        check("sb_pending", sb.size(), 0);
      end
      prev_hold = cur_hold;
    end
  end

  task automatic wait_tick(output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vga.pixel_tick && n < 64);
    if (!vga.pixel_tick) check("tick_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a"}, {vga.x, vga.y}, 0);
    check({tag, "_b"}, {vga.hsync, vga.vsync, vga.video_on, vga.pixel_tick, vga.line_start,
                        vga.frame_start}, 6'b110000);
    check({tag, "_c"}, {vga1.x, vga1.y, vga1.hsync, vga1.vsync, vga1.video_on,
                        vga1.pixel_tick}, {20'd0, 4'b1100});
  endtask

  initial begin
    int unsigned n, guard, clks, hs_low, hs_first, von_fall, vs_low, bad_vs, bad_von;
    int unsigned maxx, maxy, px, py, k;
    logic        prev_von;

    // Step 1: reset, then the first tick on the 4th clk after release.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_vals");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pre_tick_quiet", {vga.pixel_tick, vga.video_on, vga.frame_start}, 0);
      if (i == 0) check("div1_first", {vga1.x, vga1.y, vga1.pixel_tick, vga1.frame_start}, {20'd0, 2'b11});
    end
    @(negedge clk);
    check("first_tick", {vga.pixel_tick, vga.frame_start, vga.line_start, vga.video_on}, 4'b1111);
    check("first_xy", {vga.x, vga.y}, 0);

    // Step 2: one line of ticks.
    hs_low = 0; hs_first = 999; von_fall = 999; prev_von = 1'b1;
    for (int i = 0; i < HT; i++) begin
      wait_tick(n);
      check("tick_period", n, DIV);
      if (!vga.hsync) begin
        if (hs_low == 0) hs_first = 32'(vga.x);
        hs_low++;
      end
      if (prev_von && !vga.video_on && von_fall == 999) von_fall = 32'(vga.x);
      prev_von = vga.video_on;
    end
    check("line_wrap_x", 32'(vga.x), 0);
    check("line_wrap_ls", vga.line_start, 1);
    check("hsync_width", hs_low, HS);
    check("hsync_start", hs_first, HD + HF);
    check("video_on_fall", von_fall, HD);

    // Step 3/4: one full frame between frame_start pulses, with corner wrap.
    guard = 0;
    do begin wait_tick(n); guard++; end while (!vga.frame_start && guard < HT * VT + 2);
    check("frame_found", vga.frame_start, 1);
    clks = 0; vs_low = 0; bad_vs = 0; bad_von = 0; maxx = 0; maxy = 0; px = 0; py = 0; guard = 0;
    do begin
      wait_tick(n);
      clks += n;
      guard++;
      if (!vga.frame_start) begin
        if (!vga.vsync) begin
          vs_low++;
          if (vga.y < 10'(VD + VF) || vga.y >= 10'(VD + VF + VS)) bad_vs++;
        end
        if (vga.video_on && (vga.y >= 10'(VD) || vga.x >= 10'(HD))) bad_von++;
        if (32'(vga.x) > maxx) maxx = 32'(vga.x);
        if (32'(vga.y) > maxy) maxy = 32'(vga.y);
        px = 32'(vga.x);
        py = 32'(vga.y);
      end
    end while (!vga.frame_start && guard < HT * VT + 2);
    check("frame_period", clks, DIV * HT * VT);
    check("vsync_ticks", vs_low, VS * HT);
    check("vsync_range", bad_vs, 0);
    check("video_on_blank", bad_von, 0);
    check("max_x", maxx, HT - 1);
    check("max_y", maxy, VT - 1);
    check("corner_prev", {px[9:0], py[9:0]}, {10'(HT - 1), 10'(VT - 1)});
    check("corner_next", {vga.x, vga.y, vga.line_start, vga.frame_start}, {20'd0, 2'b11});

    // Step 5: asynchronous reset mid-frame, mid-divider, inside the vsync pulse.
    guard = 0;
    do begin wait_tick(n); guard++; end
    while (!(vga.x == 10'd5 && vga.y == 10'd7) && guard < HT * VT + 2);
    check("reach_5_7", {vga.x, vga.y, vga.vsync}, {10'd5, 10'd7, 1'b0});
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("held_reset");
    rst = 1'b0;
    wait_tick(n);
    check("restart_latency", n, DIV);
    check("restart_xy", {vga.x, vga.y, vga.frame_start}, {20'd0, 1'b1});

    // Step 6: CLK_DIV=1 instance has advanced one pixel per clk since the same release.
    for (k = n + 1; k <= n + 2 * HT * VT; k++) begin
      @(negedge clk);
      check("div1_tick", vga1.pixel_tick, 1);
      check("div1_xy", {vga1.x, vga1.y}, {10'((k - 1) % HT), 10'(((k - 1) / HT) % VT)});
      check("div1_frame", vga1.frame_start, 32'(((k - 1) % (HT * VT)) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
